// File: rtl/m_cla_mp_pkg.sv
`default_nettype none
// ==================================================================
// m_cla_mp_pkg : shared widths, state encodings and index-width helper
// Revision     : 1.0
// ==================================================================
package m_cla_mp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_cla32.sv
`default_nettype none
// ==================================================================
// m_cla32  : combinational 32-bit adder, 4-bit lookahead groups with
//            rippled group carries; c31 is the carry into the MSB
// Revision : 1.0
// ==================================================================
module m_cla32
  import m_cla_mp_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co,
  output logic              c31
);

  localparam int N_GRP = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] c;
  logic [N_GRP-1:0]  gg;
  logic [N_GRP-1:0]  gp;
  logic [N_GRP:0]    gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = ci;
    for (int j = 0; j < N_GRP; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j]   = &p[4*j +: 4];
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    // Bit carries inside each group look ahead from that group's carry-in.
    for (int j = 0; j < N_GRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign s   = p ^ c;
  assign co  = gc[N_GRP];
  assign c31 = c[WORD_W-1];

endmodule
`default_nettype wire

// File: rtl/m_cla_mp_ctrl.sv
`default_nettype none
// ==================================================================
// m_cla_mp_ctrl : N_WORD x 32-bit add/sub sequenced over one m_cla32
// Build option  : M_CLA_MP_OVF_EN enables the signed-overflow flag
// Revision      : 1.0
// ==================================================================
module m_cla_mp_ctrl
  import m_cla_mp_pkg::*;
#(
  parameter int N_WORD = 4
)
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  input  logic                     sub,
  input  logic [WORD_W*N_WORD-1:0] a,
  input  logic [WORD_W*N_WORD-1:0] b,
  input  logic                     ci,
  output logic [WORD_W*N_WORD-1:0] s,
  output logic                     co,
  output logic                     ovf,
  output logic                     done
);

  localparam int              TOTAL_W = WORD_W * N_WORD;
  localparam int              K_W     = clog2(N_WORD);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_WORD - 1);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               c_q, c_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic               sub_q, sub_d;
  logic [TOTAL_W-1:0] s_q, s_d;
  logic               co_q, co_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  a_k;
  logic [WORD_W-1:0]  b_k;
  logic [WORD_W-1:0]  sum_w;
  logic               co_w;
  logic               c31_w;

  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < N_WORD; i++) begin
      if (k_q == i[K_W-1:0]) begin
        a_k = a_q[i*WORD_W +: WORD_W];
        b_k = b_q[i*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
      end
    end
  end

  m_cla32 u_cla (
    .a   (a_k),
    .b   (b_k),
    .ci  (c_q),
    .s   (sum_w),
    .co  (co_w),
    .c31 (c31_w)
  );

`ifdef M_CLA_MP_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  logic unused_c31;
  assign unused_c31 = c31_w;
  assign ovf        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    s_d     = s_q;
    co_d    = co_q;
    ready_d = ready_q;
    done_d  = 1'b0;
`ifdef M_CLA_MP_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          c_d     = ci ^ sub;
          k_d     = '0;
          state_d = ST_RUN;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < N_WORD; i++) begin
          if (k_q == i[K_W-1:0]) s_d[i*WORD_W +: WORD_W] = sum_w;
        end
        c_d = co_w;
        if (k_q == K_LAST) begin
          co_d    = co_w;
`ifdef M_CLA_MP_OVF_EN
          ovf_d   = c31_w ^ co_w;
`endif
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef M_CLA_MP_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef M_CLA_MP_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign s     = s_q;
  assign co    = co_q;

endmodule
`default_nettype wire

// File: tb/tb_m_cla_mp_ctrl.sv
`default_nettype none
// ==================================================================
// tb_m_cla_mp_ctrl : directed scoreboard bench for m_cla_mp_ctrl
// Revision         : 1.0
// ==================================================================
module tb_m_cla_mp_ctrl;

  localparam int N_WORD = 4;
  localparam int W      = 32 * N_WORD;
  localparam int P      = N_WORD + 2;
`ifdef M_CLA_MP_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         ci    = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic         done;

  m_cla_mp_ctrl #(.N_WORD(N_WORD)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ready (ready),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .s     (s),
    .co    (co),
    .ovf   (ovf),
    .done  (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clock) begin
    exp_t e;
    if (done !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d actual=%b required=0", cyc, done);
      end else begin
        e = sb.pop_front();
        check("done_cycle", W'(cyc), W'(e.cyc));
        check("s", s, e.s);
        check("co", W'(co), W'(e.co));
        check("ovf", W'(ovf), W'(e.ovf));
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout cyc=%0d actual=%b required=1", cyc, ready);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tsub, input logic tci,
                       input logic [W-1:0] es, input logic eco, input logic eovf,
                       output int acc);
    exp_t e;
    wait_ready();
    a     = ta;
    b     = tb_v;
    sub   = tsub;
    ci    = tci;
    start = 1'b1;
    acc   = cyc + 1;
    e.s   = es;
    e.co  = eco;
    e.ovf = OVF_EN ? eovf : 1'b0;
    e.cyc = acc + N_WORD;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   c0;
    exp_t e;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", W'(ready), W'(1'b1));
    check("rst_done",  W'(done),  W'(1'b0));
    check("rst_s",     s,         '0);
    check("rst_co",    W'(co),    W'(1'b0));
    check("rst_ovf",   W'(ovf),   W'(1'b0));

    // All-ones carry ripple, with explicit timing of done/ready.
    do_op({W{1'b1}}, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0, acc);
    wait_cyc(acc + N_WORD - 1);
    check("pre_done_low", W'(done), W'(1'b0));
    wait_cyc(acc + N_WORD);
    check("done_ready_low", W'(ready), W'(1'b0));
    wait_cyc(acc + N_WORD + 1);
    check("ready_back", W'(ready), W'(1'b1));
    check("done_one_cycle", W'(done), W'(1'b0));

    do_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
          128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, acc);
    do_op('0, 128'h1, 1'b1, 1'b0, {W{1'b1}}, 1'b0, 1'b0, acc);
    do_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
          128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, acc);
    do_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, 1'b1, 1'b0,
          128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, acc);
    do_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
          128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0, 1'b0,
          128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321, 1'b0, 1'b0, acc);

    // Start pulses during RUN and DONE must be ignored.
    do_op(128'h5, 128'h3, 1'b1, 1'b1, 128'h1, 1'b1, 1'b0, acc);
    wait_cyc(acc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc(acc + N_WORD);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    // Start held high: one accept every P cycles.
    wait_ready();
    c0    = cyc;
    a     = 128'h5;
    b     = 128'h3;
    sub   = 1'b1;
    ci    = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.s   = 128'h1;
      e.co  = 1'b1;
      e.ovf = 1'b0;
      e.cyc = c0 + 1 + P * i + N_WORD;
      sb.push_back(e);
    end
    wait_cyc(c0 + 1 + 2 * P);
    start = 1'b0;

    // Reset during the third RUN cycle abandons the operation.
    do_op({W{1'b1}}, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0, acc);
    void'(sb.pop_back());
    wait_cyc(acc + 2);
    reset = 1'b1;
    wait_cyc(acc + 3);
    check("midrst_ready", W'(ready), W'(1'b1));
    check("midrst_done",  W'(done),  W'(1'b0));
    check("midrst_s",     s,         '0);
    check("midrst_co",    W'(co),    W'(1'b0));
    check("midrst_ovf",   W'(ovf),   W'(1'b0));
    reset = 1'b0;
    wait_cyc(acc + 3 + 2 * P);

    do_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
          128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, acc);

    wait_cyc(cyc + 3 * P);
    check("sb_drained", W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_cla_mp_ctrl.md
# m_cla_mp_ctrl

Multi-precision add/subtract sequencer that time-multiplexes a single 32-bit carry-lookahead adder over N_WORD limbs. It executes one N_WORD×32-bit operation and carries the inter-limb carry in a register between cycles. It accepts an operation through a start/ready handshake and reports completion with a one-cycle done pulse. It sits between a requesting controller and the 32-bit CLA datapath, so wide arithmetic runs without a wide adder.

## Interface
Parameters:
- N_WORD, 4, number of 32-bit limbs; legal range 2..8.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  block idle and able to accept start
- sub  in  1  0: s = a + b + ci; 1: s = a − b − ci
- a  in  32·N_WORD  operand A, sampled on accept
- b  in  32·N_WORD  operand B, sampled on accept
- ci  in  1  carry-in (add) / borrow-in (sub), sampled on accept
- s  out  32·N_WORD  result
- co  out  1  final carry-out; for sub, 1 = no borrow
- ovf  out  1  signed overflow of full-width result
- done  out  1  one-cycle pulse, s/co/ovf valid

## Operation
- FSM states: IDLE (00), RUN (01), DONE (10).
- IDLE: ready=1. If start=1, the block does the following:
  - latches a, b, sub;
  - sets carry register c = ci ^ sub;
  - sets limb index k=0;
  - moves to RUN.
- RUN: ready=0. Each cycle it does the following:
  - computes {c_next, s_k} = a_k + (b_k ^ {32{sub}}) + c;
  - writes s_k into limb k of s;
  - sets c ← c_next and k ← k+1.
- Leaving RUN: after the limb k=N_WORD−1 is written, co ← c_next and the FSM moves to DONE.
- DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
- start while ready=0 is ignored. It is not queued. A requester holding start high is accepted on the first IDLE cycle.
- s, co and ovf hold their last values until the next accepted operation overwrites them. Limbs of s update progressively during RUN, and only the done cycle guarantees validity.
- Subtraction uses two's-complement: a + ~b + ~ci. Width is exactly 32·N_WORD bits. Carry beyond co is discarded.

## Timing
- Accept at edge T (start=1, ready=1).
- RUN occupies cycles T+1 … T+N_WORD.
- done=1 during cycle T+N_WORD+1.
- ready=1 again from T+N_WORD+2. Throughput is one operation per N_WORD+2 cycles.
- Reset values:
  - state=IDLE, ready=1, done=0;
  - s=0, co=0, ovf=0;
  - c=0, k=0.
- Reset asserted in any state, including mid-RUN, behaves as follows:
  - the operation is abandoned and no done pulse is issued;
  - outputs take their reset values on the next edge.
- Reset and start in the same cycle: reset wins and start is ignored.
- The index k wraps only through the IDLE reinitialisation. It never exceeds N_WORD−1.

## Configuration
- M_CLA_MP_OVF_EN defined: on the last RUN cycle the block does the following:
  - it captures the carry into bit 31 of the top limb (c31);
  - it sets ovf ← c31 ^ c_next;
  - ovf is valid with done and holds like s.
- M_CLA_MP_OVF_EN undefined: the ovf port remains but is tied to 0, and no c31 logic is synthesised.

## Structure
- Shared package/include m_cla_mp_pkg holds the following:
  - WORD_W=32;
  - state encodings ST_IDLE, ST_RUN, ST_DONE;
  - the limb-index width function clog2(N_WORD).
- Sub-module m_cla32 is a purely combinational 32-bit CLA with ports:
  - a[31:0], b[31:0], ci;
  - s[31:0], co, c31 (carry into MSB, used for overflow).
- The controller instantiates one m_cla32. The controller owns all registers, the operand limb mux and the result limb demux.

## Test plan
All scenarios use N_WORD=4 and M_CLA_MP_OVF_EN defined.
- Add, all-ones carry ripple: a=128'hFFFF…FFFF, b=0, ci=1, sub=0, start at T. Required response:
  - done at T+5 only;
  - s=0, co=1, ovf=0;
  - ready returns at T+6.
- Limb-boundary carry: a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, ci=0. Required response: s=128'h0000_0001_0000_0000_0000_0000_0000_0000, co=0, ovf=0.
- Subtract with borrow: a=0, b=1, sub=1, ci=0. Required response: s=128'hFFFF…FFFF, co=0, ovf=0.
- Signed overflow: a=128'h7FFF…FFFF, b=1, sub=0. Required response: s=128'h8000_0000…0000, co=0, ovf=1.
- Handshake:
  - start held high continuously gives one accept per 6 cycles;
  - a start pulse during RUN or DONE produces no extra operation and no extra done.
- Reset mid-operation: assert reset during the 3rd RUN cycle. Required response:
  - next cycle ready=1, done=0, s=0, co=0, ovf=0;
  - no done pulse follows;
  - a new operation afterwards completes correctly.
